// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word request at a time, response pulse LATENCY cycles after accept.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_input_valid,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        mem_rw,
    output logic        is_ready,
    output logic        is_output_valid,
    output logic [31:0] dout,
    output logic        is_error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [7:0]      cnt, cnt_next;
    logic            accept;
    logic            enter_resp;
    logic [AW-1:0]   idx_p0;
    logic [31:0]     din_p0;
    logic            rw_p0;
    logic [AW-1:0]   idx_req;
    logic [31:0]     din_req;
    logic            rw_req;
    logic            mis_req;
    logic [31:0]     mem [DEPTH_WORDS];

    assign is_ready        = (state != WAIT);
    assign is_output_valid = (state == RESP);
    assign accept          = is_input_valid && is_ready;

    // With LATENCY=1 the response is formed on the accept edge itself, so the live inputs feed it.
    assign idx_req = accept ? addr[AW+1:2] : idx_p0;
    assign din_req = accept ? din : din_p0;
    assign rw_req  = accept ? mem_rw : rw_p0;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis_p0;
    logic err_q;
    logic unused_bits;

    assign mis_req     = accept ? (addr[1:0] != 2'b00) : mis_p0;
    assign is_error    = err_q;
    assign unused_bits = ^addr[31:AW+2];
`else
    logic unused_bits;

    assign mis_req     = 1'b0;
    assign is_error    = 1'b0;
    assign unused_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: ;
            WAIT: begin
                cnt_next = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            cnt_next = CNT_LOAD;
            if (LATENCY > 1) begin
                state_next = WAIT;
            end else begin
                state_next = RESP;
                enter_resp = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Stage p0: request capture on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_p0 <= '0;
            din_p0 <= 32'd0;
            rw_p0  <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
            mis_p0 <= 1'b0;
`endif
        end else if (accept) begin
            idx_p0 <= addr[AW+1:2];
            din_p0 <= din;
            rw_p0  <= mem_rw;
`ifdef DMEM_MISALIGN_CHECK_EN
            mis_p0 <= (addr[1:0] != 2'b00);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && rw_req && !mis_req)
            mem[idx_req] <= din_req;
    end

    // Stage p1: response data registered on entry to RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= 32'd0;
        end else if (enter_resp) begin
            if (mis_req)
                dout <= 32'd0;
            else if (rw_req)
                dout <= din_req;
            else
                dout <= mem[idx_req];
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else
            err_q <= enter_resp && mis_req;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one default instance (LATENCY=4) and one with LATENCY=1, DEPTH_WORDS=16.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        a_valid = 1'b0;
    logic [31:0] a_addr = 32'd0;
    logic [31:0] a_din = 32'd0;
    logic        a_rw = 1'b0;
    logic        a_ready, a_ov, a_err;
    logic [31:0] a_dout;

    logic        b_valid = 1'b0;
    logic [31:0] b_addr = 32'd0;
    logic [31:0] b_din = 32'd0;
    logic        b_rw = 1'b0;
    logic        b_ready, b_ov, b_err;
    logic [31:0] b_dout;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_responder u_a (
        .clk(clk), .reset(reset), .is_input_valid(a_valid), .addr(a_addr), .din(a_din),
        .mem_rw(a_rw), .is_ready(a_ready), .is_output_valid(a_ov), .dout(a_dout), .is_error(a_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_b (
        .clk(clk), .reset(reset), .is_input_valid(b_valid), .addr(b_addr), .din(b_din),
        .mem_rw(b_rw), .is_ready(b_ready), .is_output_valid(b_ov), .dout(b_dout), .is_error(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one request on instance A from IDLE and wait (bounded) for its response pulse.
    task automatic run_a(input string tag, input logic rw, input logic [31:0] ad, input logic [31:0] d,
                         output logic [31:0] rd, output logic re);
        int lat;
        check({tag, "_ready"}, a_ready, 1);
        a_valid = 1'b1; a_rw = rw; a_addr = ad; a_din = d;
        tick();
        a_valid = 1'b0; a_addr = 32'hFFFF_FFFC; a_din = 32'h0; a_rw = ~rw;
        lat = 1;
        while (!a_ov && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        rd = a_dout;
        re = a_err;
        tick();
        check({tag, "_pulse_width"}, a_ov, 0);
    endtask

    task automatic step_b(input string tag, input logic rw, input logic [31:0] ad, input logic [31:0] d,
                          input logic [31:0] exp);
        b_valid = 1'b1; b_rw = rw; b_addr = ad; b_din = d;
        check({tag, "_ready"}, b_ready, 1);
        tick();
        check({tag, "_ov"}, b_ov, 1);
        check({tag, "_dout"}, b_dout, exp);
        check({tag, "_err"}, b_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        re;
        int          pulses;
        logic [31:0] got;

        // Reset state
        #12;
        check("rst_a_ready", a_ready, 1);
        check("rst_a_ov", a_ov, 0);
        check("rst_a_dout", a_dout, 32'd0);
        check("rst_a_err", a_err, 0);
        check("rst_b_ready", b_ready, 1);
        check("rst_b_ov", b_ov, 0);
        reset = 1'b1;
        tick();

        // Write then read back at LATENCY=4
        run_a("wr100", 1'b1, 32'h100, 32'h1234_5678, rd, re);
        check("wr100_echo", rd, 32'h1234_5678);
        check("wr100_err", re, 0);
        run_a("rd100", 1'b0, 32'h100, 32'h0, rd, re);
        check("rd100_data", rd, 32'h1234_5678);
        check("rd100_err", re, 0);

        // Reset mid-WAIT drops the pending write
        run_a("wr40_pre", 1'b1, 32'h40, 32'h1111_1111, rd, re);
        a_valid = 1'b1; a_rw = 1'b1; a_addr = 32'h40; a_din = 32'hDEAD_BEEF;
        tick();
        a_valid = 1'b0;
        tick();
        check("wait_ready", a_ready, 0);
        reset = 1'b0;
        #1;
        check("midrst_ready", a_ready, 1);
        check("midrst_ov", a_ov, 0);
        check("midrst_dout", a_dout, 32'd0);
        #2;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ov) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        run_a("rd40", 1'b0, 32'h40, 32'h0, rd, re);
        check("rd40_data", rd, 32'h1111_1111);

        // Requests while busy are ignored; only the accepted address is serviced
        run_a("wr200", 1'b1, 32'h200, 32'hAAAA_0200, rd, re);
        run_a("wr204", 1'b1, 32'h204, 32'hBBBB_0204, rd, re);
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 32'h100;
        tick();
        a_addr = 32'h200;
        tick();
        a_addr = 32'h204;
        tick();
        check("busy_ov_early", a_ov, 0);
        tick();
        check("busy_resp_ov", a_ov, 1);
        check("busy_resp_dout", a_dout, 32'h1234_5678);
        check("busy_resp_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        pulses = 0;
        got = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (a_ov) begin
                pulses++;
                got = a_dout;
            end
            tick();
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_data", got, 32'hBBBB_0204);

        // Misaligned write
        run_a("mis_wr", 1'b1, 32'h102, 32'hFFFF_FFFF, rd, re);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_wr_err", re, 1);
        check("mis_wr_dout", rd, 32'h0);
        run_a("mis_rd", 1'b0, 32'h100, 32'h0, rd, re);
        check("mis_rd_data", rd, 32'h1234_5678);
`else
        check("mis_wr_err", re, 0);
        check("mis_wr_dout", rd, 32'hFFFF_FFFF);
        run_a("mis_rd", 1'b0, 32'h100, 32'h0, rd, re);
        check("mis_rd_data", rd, 32'hFFFF_FFFF);
`endif
        check("mis_rd_err", re, 0);

        // LATENCY=1 back-to-back stream, read-after-write, address wrap
        step_b("b_w0", 1'b1, 32'h0, 32'h0000_1000, 32'h0000_1000);
        step_b("b_w4", 1'b1, 32'h4, 32'h0000_2004, 32'h0000_2004);
        step_b("b_w8", 1'b1, 32'h8, 32'h0000_3008, 32'h0000_3008);
        step_b("b_wc", 1'b1, 32'hC, 32'h0000_400C, 32'h0000_400C);
        step_b("b_r0", 1'b0, 32'h0, 32'h0, 32'h0000_1000);
        step_b("b_r4", 1'b0, 32'h4, 32'h0, 32'h0000_2004);
        step_b("b_r8", 1'b0, 32'h8, 32'h0, 32'h0000_3008);
        step_b("b_rc", 1'b0, 32'hC, 32'h0, 32'h0000_400C);
        step_b("b_raw_w", 1'b1, 32'h8, 32'hCAFE_F00D, 32'hCAFE_F00D);
        step_b("b_raw_r", 1'b0, 32'h8, 32'h0, 32'hCAFE_F00D);
        step_b("b_wrap_w", 1'b1, 32'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        step_b("b_wrap_r", 1'b0, 32'h40, 32'h0, 32'hA5A5_A5A5);
        b_valid = 1'b0;
        tick();
        check("b_idle_ov", b_ov, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory side of the CPU MEM-stage load/store interface.
- Accepts one word request at a time over a valid/ready handshake and services it after a fixed, parameterised latency.
- Returns a one-cycle response pulse.
- Replaces the single-cycle data memory in the pipelined CPU, which stalls its MEM stage until the response arrives.

Parameters:
- DEPTH_WORDS, 16384, number of 32-bit words of storage; power of two.
- LATENCY, 4, cycles from request acceptance edge to response; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- is_input_valid  input  1  request present this cycle.
- addr  input  32  byte address of request.
- din  input  32  write data.
- mem_rw  input  1  0 = read, 1 = write.
- is_ready  output  1  responder can accept a request this cycle.
- is_output_valid  output  1  response pulse; one cycle per accepted request.
- dout  output  32  read data; write data echoed for writes.
- is_error  output  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Storage: DEPTH_WORDS x 32-bit array, indexed by addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - addr[1:0] is ignored unless the optional feature is enabled.
  - Array contents are not affected by reset.
- Reset (reset low, asynchronous): state=IDLE, is_ready=1, is_output_valid=0, dout=0, is_error=0, latency counter=0, captured request cleared.
  - A pending request in flight is dropped; a pending write is never committed.
- Accept: on a rising edge where is_input_valid=1 and is_ready=1, capture addr, din and mem_rw, and load counter=LATENCY-1.
- States:
  - IDLE: is_ready=1, is_output_valid=0.
    - On accept: go to WAIT if LATENCY>1, otherwise go to RESP.
  - WAIT: is_ready=0, is_output_valid=0. Counter decrements once per cycle.
    - When counter reaches 1 at the edge, go to RESP.
    - Net: is_output_valid is high exactly LATENCY cycles after the accept edge.
  - RESP: is_output_valid=1 for exactly one cycle, is_ready=1.
    - Read: dout = array[captured index], registered at entry to RESP.
    - Write: the array is updated at the edge entering RESP; dout = captured din.
    - On the RESP edge, if is_input_valid=1 the new request is accepted (go to WAIT, or stay in RESP if LATENCY=1). Otherwise go to IDLE.
- Back-to-back: with LATENCY=1 and is_input_valid held high, one response per cycle with no bubble.
- Read immediately following a write to the same word returns the new data.
- is_input_valid while is_ready=0: ignored, not queued. The requester must hold the request until accepted.
- addr/din/mem_rw changes after acceptance have no effect on the in-flight request.
- dout holds its last value outside RESP; it is meaningful only while is_output_valid=1.
- Counter width: 8 bits; no wrap occurs within the legal LATENCY range.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - A request with addr[1:0]!=0 is accepted and timed normally.
  - In RESP it gives is_output_valid=1, is_error=1, dout=0.
  - A misaligned write does not modify the array.
  - Aligned requests give is_error=0.
- Undefined:
  - is_error is tied to 0.
  - addr[1:0] is ignored and misaligned accesses act on the containing word.

Test Plan:
- Reset low mid-WAIT after write 0xDEADBEEF to 0x40 (LATENCY=4) -> is_ready=1, is_output_valid=0 immediately; later read of 0x40 returns the prior contents, not 0xDEADBEEF.
- Write 0x12345678 to 0x100, then read 0x100 (LATENCY=4) -> each is_output_valid pulse exactly 4 cycles after its accept edge, one cycle wide; read dout=0x12345678.
- LATENCY=1, is_input_valid held for 4 reads of 0x0/0x4/0x8/0xC -> 4 consecutive response cycles, no gaps, correct data each cycle.
- Request presented while is_ready=0 with addr=0x200 changing to 0x204 before acceptance -> only the accepted value is serviced; no extra response pulse.
- Address wrap with DEPTH_WORDS=16: write 0xA5A5A5A5 to 0x0, read 0x40 -> dout=0xA5A5A5A5.
- DMEM_MISALIGN_CHECK_EN defined: write 0xFFFFFFFF to 0x102 -> is_error=1, dout=0; a subsequent read of 0x100 shows an unchanged word, is_error=0.
